// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: out = in0 / in1, NBITS total bits,
// DBITS fractional, two's complement. Radix-2 restoring division producing
// one quotient bit per cycle, with valid/ready handshakes on both sides.
// Optional build macro FIXED_POINT_DIVIDER_SAT_EN: saturate the quotient on
// overflow instead of wrapping it.
module fixed_point_divider #(
  parameter int NBITS = 8,
  parameter int DBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out,
  output logic             dbz,
  output logic             ovf
);

  localparam int W  = NBITS + DBITS;   // quotient / shifted-dividend width
  localparam int CW = $clog2(W + 1);   // bit counter width

  // Largest representable magnitudes, expressed at quotient width.
  localparam logic [W-1:0] NEG_LIM = W'(1 << (NBITS - 1));
  localparam logic [W-1:0] POS_LIM = W'((1 << (NBITS - 1)) - 1);

  localparam logic [NBITS-1:0] SAT_POS = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] SAT_NEG = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sign_q,  sign_d;
  logic [NBITS-1:0] dvs_q,   dvs_d;    // |in1|
  logic [W-1:0]     dvd_q,   dvd_d;    // |in0| << DBITS, consumed MSB first
  logic [NBITS:0]   rem_q,   rem_d;
  logic [W-1:0]     quo_q,   quo_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [NBITS-1:0] out_q,   out_d;
  logic             dbz_q,   dbz_d;
  logic             ovf_q,   ovf_d;

  logic [NBITS-1:0] mag0, mag1;
  logic [NBITS+1:0] rem_shift;
  logic [NBITS+1:0] dvs_ext;
  logic             ge;
  logic [W-1:0]     quo_next;
  logic [NBITS-1:0] res_wrap;
  logic [NBITS-1:0] res_out;
  logic             res_ovf;

  // Operand magnitudes; negating the most negative value yields 2^(NBITS-1).
  always_comb begin
    mag0 = in0[NBITS-1] ? -in0 : in0;
    mag1 = in1[NBITS-1] ? -in1 : in1;
  end

  // One restoring-division step plus the signed result of the final step.
  always_comb begin
    rem_shift = {rem_q, dvd_q[W-1]};
    dvs_ext   = {2'b00, dvs_q};
    ge        = (rem_shift >= dvs_ext);
    quo_next  = (quo_q << 1) | W'(ge);
    res_wrap  = NBITS'(sign_q ? -quo_next : quo_next);
    res_ovf   = sign_q ? (quo_next > NEG_LIM) : (quo_next > POS_LIM);
`ifdef FIXED_POINT_DIVIDER_SAT_EN
    res_out   = res_ovf ? (sign_q ? SAT_NEG : SAT_POS) : res_wrap;
`else
    res_out   = res_wrap;
`endif
  end

  // Next-state and handshake outputs of the IDLE/CALC/DONE controller.
  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    sign_d  = sign_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    in_rdy  = 1'b0;
    out_val = 1'b0;

    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          sign_d = in0[NBITS-1] ^ in1[NBITS-1];
          dvs_d  = mag1;
          dvd_d  = {mag0, {DBITS{1'b0}}};
          rem_d  = '0;
          quo_d  = '0;
          ovf_d  = 1'b0;
          if (in1 == '0) begin
            // Divide by zero: report it and return the extreme matching in0's sign.
            dbz_d   = 1'b1;
            out_d   = in0[NBITS-1] ? SAT_NEG : SAT_POS;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            cnt_d   = CW'(W);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = ge ? (NBITS+1)'(rem_shift - dvs_ext) : (NBITS+1)'(rem_shift);
        quo_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = res_out;
          ovf_d   = res_ovf;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out = out_q;
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule
